// File: rtl/uart_pkg.sv
// Shared UART constants, divisor helper and phase typedef.
// Imported by the baud tick generator and its prescaler.
package uart_pkg;

  localparam int UART_CNT_W      = 24;
  localparam int UART_OVERSAMPLE = 16;

  typedef logic [$clog2(UART_OVERSAMPLE)-1:0] phase_t;

  // Sample period is (result + 1) clocks, so subtract one.
  function automatic int uartDefaultDiv(
    input longint clkHz,
    input longint baud
  );
    return int'(clkHz / (baud * UART_OVERSAMPLE)) - 1;
  endfunction

endpackage

// File: rtl/sample_prescaler.sv
// Sample prescaler: SampleCnt, pending/active divisor, wrap strobe.
// Optional FRACTIONAL_DIV_EN adds a fractional period accumulator.
module sample_prescaler
  import uart_pkg::*;
#(
  parameter int CNT_W       = UART_CNT_W,
  parameter int DEFAULT_DIV = 650
`ifdef FRACTIONAL_DIV_EN
  ,
  parameter int FRAC_W      = 4
`endif
) (
  input  logic             SystemClock,
  input  logic             ResetTimer,
  input  logic             Enable,
  input  logic [CNT_W-1:0] Divisor,
  input  logic             LoadDivisor,
  input  logic             Restart,
`ifdef FRACTIONAL_DIV_EN
  input  logic [FRAC_W-1:0] DivisorFrac,
`endif
  output logic             Wrap,
  output logic [CNT_W-1:0] DivisorActive
);

  logic [CNT_W-1:0] sampleCnt;
  logic [CNT_W-1:0] pendingDiv;
  logic             loadPending;
  logic             atTop;
`ifdef FRACTIONAL_DIV_EN
  logic [FRAC_W-1:0] pendingFrac;
  logic [FRAC_W-1:0] fracActive;
  logic [FRAC_W-1:0] fracAcc;
  logic              stretch;
`endif

  // Wrap when the count reaches the divisor (after any stretch clock).
  always_comb begin
    atTop = (sampleCnt == DivisorActive);
`ifdef FRACTIONAL_DIV_EN
    Wrap  = Enable && !Restart && atTop && !stretch;
`else
    Wrap  = Enable && !Restart && atTop;
`endif
  end

  // Counter, divisor hand-over at wrap/restart, fractional accumulator.
  always_ff @(posedge SystemClock) begin
    if (ResetTimer) begin
      sampleCnt     <= '0;
      DivisorActive <= CNT_W'(DEFAULT_DIV);
      pendingDiv    <= '0;
      loadPending   <= 1'b0;
`ifdef FRACTIONAL_DIV_EN
      pendingFrac   <= '0;
      fracActive    <= '0;
      fracAcc       <= '0;
      stretch       <= 1'b0;
`endif
    end else begin
      if (LoadDivisor) begin
        pendingDiv  <= Divisor;
`ifdef FRACTIONAL_DIV_EN
        pendingFrac <= DivisorFrac;
`endif
      end
      if (Restart) begin
        sampleCnt   <= '0;
        loadPending <= 1'b0;
`ifdef FRACTIONAL_DIV_EN
        fracAcc     <= '0;
        stretch     <= 1'b0;
`endif
        if (LoadDivisor) begin
          DivisorActive <= Divisor;
`ifdef FRACTIONAL_DIV_EN
          fracActive    <= DivisorFrac;
`endif
        end else if (loadPending) begin
          DivisorActive <= pendingDiv;
`ifdef FRACTIONAL_DIV_EN
          fracActive    <= pendingFrac;
`endif
        end
      end else if (Wrap) begin
        sampleCnt   <= '0;
        loadPending <= LoadDivisor;
        if (loadPending) begin
          DivisorActive <= pendingDiv;
`ifdef FRACTIONAL_DIV_EN
          fracActive    <= pendingFrac;
`endif
        end
`ifdef FRACTIONAL_DIV_EN
        {stretch, fracAcc} <=
          {1'b0, fracAcc} + {1'b0, fracActive};
`endif
      end else begin
        if (LoadDivisor) loadPending <= 1'b1;
        if (Enable) begin
`ifdef FRACTIONAL_DIV_EN
          if (atTop) stretch <= 1'b0;
          else sampleCnt <= sampleCnt + CNT_W'(1);
`else
          sampleCnt <= sampleCnt + CNT_W'(1);
`endif
        end
      end
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud/oversample tick generator: SampleTick, NextBit, MidBit.
// Optional fractional divisor via FRACTIONAL_DIV_EN (adds DivisorFrac).
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CNT_W       = UART_CNT_W,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int DEFAULT_DIV = uartDefaultDiv(100_000_000, 9600),
  parameter int FRAC_W      = 4
) (
  input  logic             SystemClock,
  input  logic             ResetTimer,
  input  logic             Enable,
  input  logic [CNT_W-1:0] Divisor,
  input  logic             LoadDivisor,
  input  logic             Restart,
`ifdef FRACTIONAL_DIV_EN
  input  logic [FRAC_W-1:0] DivisorFrac,
`endif
  output logic             SampleTick,
  output logic             NextBit,
  output logic             MidBit,
  output logic [CNT_W-1:0] DivisorActive
);

  localparam int PH_W = $clog2(OVERSAMPLE);

  if (OVERSAMPLE < 2 || OVERSAMPLE > 64 ||
      (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
      FRAC_W < 1) begin : gBadCfg
    $error("baud_tick_gen: bad OVERSAMPLE or FRAC_W");
  end

  logic            wrap;
  logic [PH_W-1:0] phaseCnt;

  sample_prescaler #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
`ifdef FRACTIONAL_DIV_EN
    ,
    .FRAC_W      (FRAC_W)
`endif
  ) uPrescaler (
    .SystemClock   (SystemClock),
    .ResetTimer    (ResetTimer),
    .Enable        (Enable),
    .Divisor       (Divisor),
    .LoadDivisor   (LoadDivisor),
    .Restart       (Restart),
`ifdef FRACTIONAL_DIV_EN
    .DivisorFrac   (DivisorFrac),
`endif
    .Wrap          (wrap),
    .DivisorActive (DivisorActive)
  );

  // Phase counter and registered strobes decoded from the sample wrap.
  always_ff @(posedge SystemClock) begin
    if (ResetTimer || Restart) begin
      phaseCnt   <= '0;
      SampleTick <= 1'b0;
      NextBit    <= 1'b0;
      MidBit     <= 1'b0;
    end else begin
      SampleTick <= wrap;
      NextBit    <= wrap &&
                    (phaseCnt == PH_W'(OVERSAMPLE - 1));
      MidBit     <= wrap &&
                    (phaseCnt == PH_W'(OVERSAMPLE / 2 - 1));
      if (wrap) phaseCnt <= phaseCnt + PH_W'(1);
    end
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Programmable baud/oversample tick generator for the UART project; the parametrised successor of the fixed-count bit timer.
- Produces a 1-cycle oversample strobe, a 1-cycle bit strobe every OVERSAMPLE samples, and a mid-bit strobe for RX centre sampling.
- The divisor is runtime-loadable and phase restart is supported.
- Feeds both the UART TX shifter (NextBit) and the RX sampler (SampleTick, MidBit).

Parameters:
- CNT_W, 24, width of the sample prescaler counter and Divisor port.
- OVERSAMPLE, 16, samples per bit; power of two, 2..64.
- DEFAULT_DIV, 650, divisor loaded at reset. Sample period is DEFAULT_DIV+1 clocks; 650 gives 100 MHz / (9600*16).
- FRAC_W, 4, fractional divisor width; used only with FRACTIONAL_DIV_EN.

Ports:
- SystemClock  in  1  sole clock, rising edge.
- ResetTimer  in  1  synchronous, active-high reset.
- Enable  in  1  counters advance only while high.
- Divisor  in  CNT_W  new sample divisor value.
- LoadDivisor  in  1  1-cycle strobe; captures Divisor.
- Restart  in  1  1-cycle strobe; re-phases counters (RX start-edge align).
- SampleTick  out  1  1-cycle strobe each sample period.
- NextBit  out  1  1-cycle strobe each bit period, coincident with a SampleTick.
- MidBit  out  1  1-cycle strobe at sample OVERSAMPLE/2 of each bit, coincident with a SampleTick.
- DivisorActive  out  CNT_W  divisor currently in use.

Behaviour:
- Reset (ResetTimer=1 at a clock edge):
  - SampleCnt=0, PhaseCnt=0, DivisorActive=DEFAULT_DIV, pending-load flag cleared.
  - SampleTick=NextBit=MidBit=0.
  - Reset has priority over all other inputs.
- All outputs are registered. Strobes are high for exactly one cycle, and never high while ResetTimer=1 or in the cycle after reset.
- Sample prescaler, each edge with Enable=1:
  - If SampleCnt==DivisorActive: SampleCnt<=0 and SampleTick<=1.
  - Otherwise SampleCnt<=SampleCnt+1 and SampleTick<=0.
  - Period = DivisorActive+1 clocks. Divisor 0 gives SampleTick every cycle while enabled.
- Phase counter (log2(OVERSAMPLE) bits):
  - Increments on each sample wrap and wraps modulo OVERSAMPLE.
  - NextBit<=1 on the sample wrap where PhaseCnt==OVERSAMPLE-1.
  - MidBit<=1 on the sample wrap where PhaseCnt==OVERSAMPLE/2-1.
- Enable=0: all counters hold; SampleTick/NextBit/MidBit forced 0 next cycle; no tick is lost or duplicated on re-enable.
- LoadDivisor:
  - Divisor is captured into a pending register.
  - It transfers to DivisorActive on the next sample wrap, so no truncated or runaway period occurs.
  - A second load before that wrap overwrites the pending value (last wins).
- Restart: SampleCnt<=0, PhaseCnt<=0, strobes 0 next cycle. The first SampleTick follows DivisorActive+1 enabled cycles later.
- Simultaneous Restart+LoadDivisor: the new divisor takes effect immediately (the restart counts as a wrap).
- Restart with Enable=0: counters still zeroed.
- Reset mid-period: counters abort, DivisorActive returns to DEFAULT_DIV, and any pending load is discarded.
- Counter width: comparisons are at full CNT_W; no overflow path exists because SampleCnt never exceeds DivisorActive.

Optional Feature:
- Macro: FRACTIONAL_DIV_EN.
- Defined:
  - Adds input DivisorFrac [FRAC_W-1:0], captured together with Divisor by LoadDivisor and applied on the same wrap.
  - An FRAC_W-bit accumulator adds DivisorFrac on each sample wrap; on carry-out, the next sample period is one clock longer.
  - Average period = DivisorActive+1+DivisorFrac/2^FRAC_W.
  - Accumulator cleared by reset and Restart.
- Undefined: port DivisorFrac is absent and the period is exactly integer.

Decomposition:
- Package uart_pkg:
  - UART_CNT_W and UART_OVERSAMPLE constants.
  - Function computing the default divisor from clock Hz and baud.
  - Phase-count typedef sized $clog2(OVERSAMPLE).
- One sub-module, sample_prescaler: the SampleCnt, pending/active divisor and fractional accumulator, outputting the wrap strobe.
- The phase counter and NextBit/MidBit decode stay in the top.

Test Plan:
- Reset, Enable=1, load Divisor=3, OVERSAMPLE=16 → SampleTick every 4 clocks, NextBit every 64 clocks, MidBit 32 clocks before each NextBit.
- Divisor=0 → SampleTick high every enabled cycle; NextBit every 16 cycles.
- Mid-period LoadDivisor 3→9 → current period completes at 4 clocks, subsequent periods 10 clocks; DivisorActive updates at the wrap.
- Enable low for 7 cycles at SampleCnt=2 → no strobes; after re-enable the next SampleTick arrives after the remaining 2 clocks (Divisor=3).
- Restart at PhaseCnt=9, together with LoadDivisor=5 → SampleTick 6 clocks later; NextBit 96 clocks after Restart.
- FRACTIONAL_DIV_EN, Divisor=3, DivisorFrac=8, FRAC_W=4 → sample periods alternate 4,5 clocks; 16 samples take 72 clocks.
